// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch bank: mode encodings and read-index sizing.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_HOLD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // The read index is sized so that an out-of-range channel number can always
    // be expressed, even when CHANNELS is an exact power of two.
    function automatic int sel_width(input int channels);
        return $clog2(channels + 1);
    endfunction

endpackage

// File: rtl/latch_bank_cell.sv
// One WIDTH-bit storage channel: next-value mux, register, complement output
// and a one-cycle change pulse.
module latch_cell
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_LOAD:  if (load_en)  q_next = d;
            MODE_HOLD:  q_next = q;
            MODE_SHIFT: if (shift_en) q_next = shift_in;
            MODE_CLEAR: if (load_en)  q_next = '0;
            default:    q_next = q;
        endcase
    end

    // Reset clears the pulse as well, so returning to zero never reports a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            changed <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= (q_next != q);
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/latch_bank.sv
// Bank of CHANNELS storage channels with load/hold/shift/clear modes and a
// registered single-channel read port.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       En,
    input  logic [1:0]                Mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Rd_req,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS*WIDTH-1:0] Qn,
    output logic [CHANNELS-1:0]       Changed,
    output logic [WIDTH-1:0]          Rd_data,
    output logic                      Rd_valid
);

    mode_e            mode;
    logic [WIDTH-1:0] q_arr      [CHANNELS];
    logic [WIDTH-1:0] qn_arr     [CHANNELS];
    logic [WIDTH-1:0] q_next_arr [CHANNELS];
    logic [WIDTH-1:0] shift_src  [CHANNELS];
    logic [WIDTH-1:0] rd_next;

    assign mode = mode_e'(Mode);

    // En[0] gates the entire shift chain; channel 0 is fed from D.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        if (i == 0) begin : g_head
            assign shift_src[i] = D[0 +: WIDTH];
        end else begin : g_body
            assign shift_src[i] = q_arr[i-1];
        end

        latch_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (Clk),
            .rst      (Rst),
            .mode     (mode),
            .load_en  (En[i]),
            .shift_en (En[0]),
            .d        (D[i*WIDTH +: WIDTH]),
            .shift_in (shift_src[i]),
            .q_next   (q_next_arr[i]),
            .q        (q_arr[i]),
            .qn       (qn_arr[i]),
            .changed  (Changed[i])
        );

        assign Q[i*WIDTH +: WIDTH]  = q_arr[i];
        assign Qn[i*WIDTH +: WIDTH] = qn_arr[i];
    end

    // Reads return the post-edge value, so they look at the next-state values.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Sel == SEL_W'(i)) rd_next = q_next_arr[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rd_valid <= 1'b0;
            Rd_data  <= '0;
        end else begin
            Rd_valid <= Rd_req;
            if (Rd_req) Rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_latch_bank.sv
// Directed self-checking bench for latch_bank with hand-computed expectations.
module tb_latch_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic        Clk;
    logic        Rst;
    logic [31:0] D;
    logic [3:0]  En;
    logic [1:0]  Mode;
    logic [2:0]  Sel;
    logic        Rd_req;
    logic [31:0] Q;
    logic [31:0] Qn;
    logic [3:0]  Changed;
    logic [7:0]  Rd_data;
    logic        Rd_valid;

    int vec_count;
    int miscompares;

    latch_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .D        (D),
        .En       (En),
        .Mode     (Mode),
        .Sel      (Sel),
        .Rd_req   (Rd_req),
        .Q        (Q),
        .Qn       (Qn),
        .Changed  (Changed),
        .Rd_data  (Rd_data),
        .Rd_valid (Rd_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] mode,
                                 input logic [3:0] en, input logic [31:0] d,
                                 input logic rd_req, input logic [2:0] sel);
        Rst    = rst;
        Mode   = mode;
        En     = en;
        D      = d;
        Rd_req = rd_req;
        Sel    = sel;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        Rst = 1'b1; Mode = 2'b01; En = '0; D = '0; Rd_req = 1'b0; Sel = '0;
        @(negedge Clk);

        applyStimulus(1'b1, 2'b01, 4'h0, 32'h0, 1'b0, 3'd0);
        checkOutput("reset_q",       Q,               32'h0);
        checkOutput("reset_qn",      Qn,              32'hFFFFFFFF);
        checkOutput("reset_changed", {28'h0, Changed}, 32'h0);
        checkOutput("reset_rvalid",  {31'h0, Rd_valid}, 32'h0);
        checkOutput("reset_rdata",   {24'h0, Rd_data}, 32'h0);

        applyStimulus(1'b0, 2'b00, 4'b0101, 32'hA1B2C3D4, 1'b0, 3'd0);
        checkOutput("load_q",       Q,               32'h00B200D4);
        checkOutput("load_qn",      Qn,              32'hFF4DFF2B);
        checkOutput("load_changed", {28'h0, Changed}, 32'h5);

        applyStimulus(1'b0, 2'b01, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0);
        checkOutput("hold_pulse_gone", {28'h0, Changed}, 32'h0);
        checkOutput("hold_q",          Q,               32'h00B200D4);

        applyStimulus(1'b0, 2'b10, 4'b0001, 32'h00000011, 1'b0, 3'd0);
        checkOutput("shift1_q", Q, 32'hB200D411);
        applyStimulus(1'b0, 2'b10, 4'b0001, 32'h00000022, 1'b0, 3'd0);
        checkOutput("shift2_q", Q, 32'h00D41122);
        applyStimulus(1'b0, 2'b10, 4'b0001, 32'h00000033, 1'b0, 3'd0);
        checkOutput("shift3_q", Q, 32'hD4112233);
        applyStimulus(1'b0, 2'b10, 4'b0001, 32'h00000044, 1'b0, 3'd0);
        checkOutput("shift4_q",       Q,               32'h11223344);
        checkOutput("shift4_changed", {28'h0, Changed}, 32'hF);

        applyStimulus(1'b0, 2'b10, 4'b1110, 32'h000000FF, 1'b0, 3'd0);
        checkOutput("shift_gated_q",       Q,               32'h11223344);
        checkOutput("shift_gated_changed", {28'h0, Changed}, 32'h0);

        applyStimulus(1'b0, 2'b00, 4'b0010, 32'h00003300, 1'b0, 3'd0);
        checkOutput("same_load_q",       Q,               32'h11223344);
        checkOutput("same_load_changed", {28'h0, Changed}, 32'h0);

        applyStimulus(1'b0, 2'b01, 4'h0, 32'h0, 1'b1, 3'd5);
        checkOutput("rd_oor_valid", {31'h0, Rd_valid}, 32'h1);
        checkOutput("rd_oor_data",  {24'h0, Rd_data}, 32'h0);

        applyStimulus(1'b0, 2'b00, 4'b0100, 32'h005A0000, 1'b1, 3'd2);
        checkOutput("rd_load_valid",   {31'h0, Rd_valid}, 32'h1);
        checkOutput("rd_load_data",    {24'h0, Rd_data}, 32'h5A);
        checkOutput("rd_load_q",       Q,               32'h115A3344);
        checkOutput("rd_load_changed", {28'h0, Changed}, 32'h4);

        applyStimulus(1'b0, 2'b01, 4'h0, 32'h0, 1'b1, 3'd0);
        checkOutput("rd_b2b_valid", {31'h0, Rd_valid}, 32'h1);
        checkOutput("rd_b2b_data",  {24'h0, Rd_data}, 32'h44);

        applyStimulus(1'b0, 2'b01, 4'h0, 32'h0, 1'b0, 3'd3);
        checkOutput("rd_idle_valid", {31'h0, Rd_valid}, 32'h0);
        checkOutput("rd_idle_data",  {24'h0, Rd_data}, 32'h44);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 2'b01, 4'hF, $urandom, 1'b0, 3'd0);
            checkOutput("hold_rand_q",       Q,               32'h115A3344);
            checkOutput("hold_rand_changed", {28'h0, Changed}, 32'h0);
        end

        applyStimulus(1'b1, 2'b10, 4'b0001, 32'h000000FF, 1'b1, 3'd1);
        checkOutput("rst_mid_q",       Q,               32'h0);
        checkOutput("rst_mid_qn",      Qn,              32'hFFFFFFFF);
        checkOutput("rst_mid_rvalid",  {31'h0, Rd_valid}, 32'h0);
        checkOutput("rst_mid_rdata",   {24'h0, Rd_data}, 32'h0);
        checkOutput("rst_mid_changed", {28'h0, Changed}, 32'h0);

        applyStimulus(1'b0, 2'b00, 4'hF, 32'hCAFEBABE, 1'b1, 3'd3);
        checkOutput("reload_q",       Q,               32'hCAFEBABE);
        checkOutput("reload_rdata",   {24'h0, Rd_data}, 32'hCA);
        checkOutput("reload_rvalid",  {31'h0, Rd_valid}, 32'h1);
        checkOutput("reload_changed", {28'h0, Changed}, 32'hF);

        applyStimulus(1'b0, 2'b11, 4'b1000, 32'h0, 1'b0, 3'd0);
        checkOutput("clear_q",       Q,               32'h00FEBABE);
        checkOutput("clear_qn",      Qn,              32'hFF014541);
        checkOutput("clear_changed", {28'h0, Changed}, 32'h8);

        applyStimulus(1'b0, 2'b11, 4'b1000, 32'h0, 1'b0, 3'd0);
        checkOutput("clear_again_changed", {28'h0, Changed}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
